// File: rtl/cv32e40p_apu_arbiter.sv
// Shares one APU/FPU among NUM_CORES cv32e40p cores. Requests are arbitrated
// round-robin, with the grant held on one core while the APU stalls. In-order
// results are routed back through a FIFO of requester IDs.
module cv32e40p_apu_arbiter #(
  parameter int unsigned NUM_CORES    = 4,
  parameter int unsigned APU_NARGS    = 3,
  parameter int unsigned APU_WOP      = 6,
  parameter int unsigned APU_NDSFLAGS = 15,
  parameter int unsigned APU_NUSFLAGS = 5,
  parameter int unsigned MAX_OUTST    = 4
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic [NUM_CORES-1:0]                       core_req_i,
  output logic [NUM_CORES-1:0]                       core_gnt_o,
  input  logic [NUM_CORES-1:0][APU_NARGS-1:0][31:0]  core_operands_i,
  input  logic [NUM_CORES-1:0][APU_WOP-1:0]          core_op_i,
  input  logic [NUM_CORES-1:0][APU_NDSFLAGS-1:0]     core_flags_i,
  output logic [NUM_CORES-1:0]                       core_rvalid_o,
  output logic [31:0]                                core_result_o,
  output logic [APU_NUSFLAGS-1:0]                    core_flags_o,
  output logic                                       apu_req_o,
  input  logic                                       apu_gnt_i,
  output logic [APU_NARGS-1:0][31:0]                 apu_operands_o,
  output logic [APU_WOP-1:0]                         apu_op_o,
  output logic [APU_NDSFLAGS-1:0]                    apu_flags_o,
  input  logic                                       apu_rvalid_i,
  input  logic [31:0]                                apu_result_i,
  input  logic [APU_NUSFLAGS-1:0]                    apu_flags_i,
  output logic [$clog2(MAX_OUTST):0]                 outstanding_o,
  output logic                                       err_o
);

  localparam int unsigned IDX_W = $clog2(NUM_CORES);
  localparam int unsigned PTR_W = $clog2(MAX_OUTST);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic {IDLE, WAIT_GNT} state_e;

  state_e           state_q, state_d;
  idx_t             rr_q, lock_q, winner, sel, head;
  logic             full, handshake, pop;
  idx_t             fifo_mem [MAX_OUTST];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign full      = (cnt_q == CNT_W'(MAX_OUTST));
  assign handshake = apu_req_o & apu_gnt_i;
  assign pop       = apu_rvalid_i & (cnt_q != '0);
  assign head      = fifo_mem[rd_ptr_q];

  assign apu_operands_o = core_operands_i[sel];
  assign apu_op_o       = core_op_i[sel];
  assign apu_flags_o    = core_flags_i[sel];
  assign core_result_o  = apu_result_i;
  assign core_flags_o   = apu_flags_i;
  assign outstanding_o  = cnt_q;
  assign err_o          = err_q;

  // Round-robin search: scan from the farthest slot back toward the pointer,
  // so the last hit written is the first requester at or after rr_q.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    int idx;
    winner = rr_q;
    idx    = 0;
    for (int k = int'(NUM_CORES) - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= int'(NUM_CORES)) idx -= int'(NUM_CORES);
      if (core_req_i[idx]) winner = idx_t'(idx);
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: stall on an ungranted request, release on grant.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (apu_req_o && !apu_gnt_i) state_d = WAIT_GNT;
      WAIT_GNT: if (apu_gnt_i)               state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FSM outputs: request and source selection; WAIT_GNT ignores full and other cores.
  always_comb begin
    apu_req_o = 1'b0;
    sel       = winner;
    case (state_q)
      IDLE:     apu_req_o = (|core_req_i) & ~full;
      WAIT_GNT: begin
        apu_req_o = 1'b1;
        sel       = lock_q;
      end
      default:  apu_req_o = 1'b0;
    endcase
  end

  // One-hot per-core grant and result-valid strobes.
  always_comb begin
    core_gnt_o    = '0;
    core_rvalid_o = '0;
    if (handshake) core_gnt_o[sel]     = 1'b1;
    if (pop)       core_rvalid_o[head] = 1'b1;
  end

  // Round-robin pointer and locked index.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q   <= '0;
      lock_q <= '0;
    end else begin
      if (handshake) rr_q <= (sel == idx_t'(NUM_CORES - 1)) ? '0 : sel + 1'b1;
      if (state_q == IDLE && apu_req_o && !apu_gnt_i) lock_q <= winner;
    end
  end

  // Requester-ID FIFO storage.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is not reset; entries are only read while the count says they are valid.
    if (handshake) fifo_mem[wr_ptr_q] <= sel;
  end

  // FIFO pointers, outstanding count and sticky spurious-response flag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (handshake) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)       rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({handshake, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (apu_rvalid_i && cnt_q == '0) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Bench for cv32e40p_apu_arbiter: directed scenarios plus a randomized run
// checked against a queue-based behavioural model of the arbiter.
module tb_cv32e40p_apu_arbiter;

  localparam int N   = 4;
  localparam int NA  = 3;
  localparam int WOP = 6;
  localparam int NDS = 15;
  localparam int NUS = 5;
  localparam int MO  = 4;

  logic                         clk = 1'b0;
  logic                         rst_ni;
  logic [N-1:0]                 core_req;
  logic [N-1:0]                 core_gnt;
  logic [N-1:0][NA-1:0][31:0]   core_operands;
  logic [N-1:0][WOP-1:0]        core_op;
  logic [N-1:0][NDS-1:0]        core_flags;
  logic [N-1:0]                 core_rvalid;
  logic [31:0]                  core_result;
  logic [NUS-1:0]               core_flags_out;
  logic                         apu_req;
  logic                         apu_gnt;
  logic [NA-1:0][31:0]          apu_operands;
  logic [WOP-1:0]               apu_op;
  logic [NDS-1:0]               apu_flags;
  logic                         apu_rvalid;
  logic [31:0]                  apu_result;
  logic [NUS-1:0]               apu_flags_in;
  logic [$clog2(MO):0]          outstanding;
  logic                         err;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state.
  int     m_rr;
  bit     m_waiting;
  int     m_lock;
  int     m_q[$];
  bit     m_err;
  bit     exp_req;
  int     exp_sel;
  logic [N-1:0] exp_gnt;
  logic [N-1:0] exp_rvalid;

  cv32e40p_apu_arbiter #(
    .NUM_CORES(N), .APU_NARGS(NA), .APU_WOP(WOP),
    .APU_NDSFLAGS(NDS), .APU_NUSFLAGS(NUS), .MAX_OUTST(MO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .core_req_i(core_req), .core_gnt_o(core_gnt),
    .core_operands_i(core_operands), .core_op_i(core_op), .core_flags_i(core_flags),
    .core_rvalid_o(core_rvalid), .core_result_o(core_result), .core_flags_o(core_flags_out),
    .apu_req_o(apu_req), .apu_gnt_i(apu_gnt),
    .apu_operands_o(apu_operands), .apu_op_o(apu_op), .apu_flags_o(apu_flags),
    .apu_rvalid_i(apu_rvalid), .apu_result_i(apu_result), .apu_flags_i(apu_flags_in),
    .outstanding_o(outstanding), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs;
    core_req = '0; apu_gnt = 1'b0; apu_rvalid = 1'b0;
    apu_result = '0; apu_flags_in = '0;
    core_operands = '0; core_op = '0; core_flags = '0;
  endtask

  task automatic randomize_payload;
    for (int c = 0; c < N; c++) begin
      for (int a = 0; a < NA; a++) core_operands[c][a] = $urandom;
      core_op[c]    = WOP'($urandom);
      core_flags[c] = NDS'($urandom);
    end
    apu_result   = $urandom;
    apu_flags_in = NUS'($urandom);
  endtask

  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset;
    idle_inputs();
    rst_ni = 1'b0;
    cyc();
    rst_ni = 1'b1;
  endtask

  task automatic model_reset;
    m_rr = 0; m_waiting = 0; m_lock = 0; m_err = 0;
    m_q.delete();
  endtask

  // Expected combinational behaviour for the inputs currently applied.
  task automatic model_predict;
    exp_req = 0; exp_sel = 0; exp_gnt = '0; exp_rvalid = '0;
    if (m_waiting) begin
      exp_req = 1; exp_sel = m_lock;
    end else if (core_req != '0 && m_q.size() < MO) begin
      exp_req = 1;
      for (int k = 0; k < N; k++) begin
        if (core_req[(m_rr + k) % N]) begin
          exp_sel = (m_rr + k) % N;
          break;
        end
      end
    end
    if (exp_req && apu_gnt) exp_gnt[exp_sel] = 1'b1;
    if (apu_rvalid && m_q.size() > 0) exp_rvalid[m_q[0]] = 1'b1;
  endtask

  // Model state update at the clock edge.
  task automatic model_commit;
    if (!rst_ni) begin
      model_reset();
    end else begin
      if (apu_rvalid && m_q.size() == 0) m_err = 1;
      if (apu_rvalid && m_q.size() > 0)  void'(m_q.pop_front());
      if (exp_req && apu_gnt) begin
        m_q.push_back(exp_sel);
        m_rr = (exp_sel + 1) % N;
        m_waiting = 0;
      end else if (exp_req) begin
        m_waiting = 1;
        m_lock = exp_sel;
      end
    end
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_ni = 1'b0;
    cyc();
    #1;
    n_vec++; if (apu_req !== 1'b0) begin n_err++; $display("FAIL reset_apu_req: got %b expected 0", apu_req); end
    n_vec++; if (core_gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt: got %b expected 0000", core_gnt); end
    n_vec++; if (core_rvalid !== 4'b0000) begin n_err++; $display("FAIL reset_rvalid: got %b expected 0000", core_rvalid); end
    n_vec++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", err); end
    rst_ni = 1'b1;
  endtask

  task automatic test_single;
    logic [WOP-1:0] op1;
    apply_reset();
    randomize_payload();
    op1 = core_op[1];
    core_req = 4'b0010; apu_gnt = 1'b1;
    #1;
    n_vec++; if (core_gnt !== 4'b0010) begin n_err++; $display("FAIL single_gnt: got %b expected 0010", core_gnt); end
    n_vec++; if (apu_op !== op1) begin n_err++; $display("FAIL single_op: got %h expected %h", apu_op, op1); end
    cyc();
    core_req = '0;
    cyc();
    apu_rvalid = 1'b1; apu_result = 32'hCAFE_0001; apu_flags_in = 5'h13;
    #1;
    n_vec++; if (core_rvalid !== 4'b0010) begin n_err++; $display("FAIL single_rvalid: got %b expected 0010", core_rvalid); end
    n_vec++; if (core_result !== 32'hCAFE_0001) begin n_err++; $display("FAIL single_result: got %h expected cafe0001", core_result); end
    n_vec++; if (core_flags_out !== 5'h13) begin n_err++; $display("FAIL single_flags: got %h expected 13", core_flags_out); end
    cyc();
    apu_rvalid = 1'b0;
    #1;
    n_vec++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL single_drain: got %0d expected 0", outstanding); end
  endtask

  task automatic test_round_robin;
    logic [N-1:0] eg, er;
    apply_reset();
    core_req = 4'hF; apu_gnt = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      apu_rvalid = (k > 0);
      eg = 4'b0001 << (k % 4);
      er = (k > 0) ? (4'b0001 << ((k - 1) % 4)) : 4'b0000;
      #1;
      n_vec++; if (core_gnt !== eg) begin n_err++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, core_gnt, eg); end
      n_vec++; if (core_rvalid !== er) begin n_err++; $display("FAIL rr_rvalid[%0d]: got %b expected %b", k, core_rvalid, er); end
      n_vec++; if (outstanding !== ((k > 0) ? 3'd1 : 3'd0)) begin n_err++; $display("FAIL rr_outstanding[%0d]: got %0d", k, outstanding); end
      cyc();
    end
    core_req = '0; apu_rvalid = 1'b1;
    #1;
    n_vec++; if (core_rvalid !== 4'b0001) begin n_err++; $display("FAIL rr_last_rvalid: got %b expected 0001", core_rvalid); end
    cyc();
    apu_rvalid = 1'b0;
  endtask

  task automatic test_wait_gnt;
    apply_reset();
    core_op[0] = 6'h05; core_op[1] = 6'h0A; core_op[2] = 6'h15; core_op[3] = 6'h2A;
    core_req = 4'b1100; apu_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) core_req = 4'b1101;
      #1;
      n_vec++; if (apu_req !== 1'b1) begin n_err++; $display("FAIL wait_req[%0d]: got %b expected 1", i, apu_req); end
      n_vec++; if (apu_op !== 6'h15) begin n_err++; $display("FAIL wait_op[%0d]: got %h expected 15", i, apu_op); end
      n_vec++; if (core_gnt !== 4'b0000) begin n_err++; $display("FAIL wait_gnt_none[%0d]: got %b expected 0000", i, core_gnt); end
      cyc();
    end
    apu_gnt = 1'b1;
    #1;
    n_vec++; if (core_gnt !== 4'b0100) begin n_err++; $display("FAIL wait_grant: got %b expected 0100", core_gnt); end
    cyc();
    core_req = 4'b1001;
    #1;
    n_vec++; if (core_gnt !== 4'b1000) begin n_err++; $display("FAIL wait_next: got %b expected 1000", core_gnt); end
    n_vec++; if (apu_op !== 6'h2A) begin n_err++; $display("FAIL wait_next_op: got %h expected 2a", apu_op); end
    cyc();
    core_req = '0; apu_gnt = 1'b0; apu_rvalid = 1'b1;
    #1;
    n_vec++; if (core_rvalid !== 4'b0100) begin n_err++; $display("FAIL wait_resp0: got %b expected 0100", core_rvalid); end
    cyc();
    #1;
    n_vec++; if (core_rvalid !== 4'b1000) begin n_err++; $display("FAIL wait_resp1: got %b expected 1000", core_rvalid); end
    cyc();
    apu_rvalid = 1'b0;
  endtask

  task automatic test_full;
    logic [N-1:0] e;
    apply_reset();
    core_req = 4'hF; apu_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e = 4'b0001 << k;
      #1;
      n_vec++; if (core_gnt !== e) begin n_err++; $display("FAIL full_fill[%0d]: got %b expected %b", k, core_gnt, e); end
      cyc();
    end
    #1;
    n_vec++; if (outstanding !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d expected 4", outstanding); end
    n_vec++; if (apu_req !== 1'b0) begin n_err++; $display("FAIL full_req: got %b expected 0", apu_req); end
    n_vec++; if (core_gnt !== 4'b0000) begin n_err++; $display("FAIL full_gnt: got %b expected 0000", core_gnt); end
    apu_rvalid = 1'b1;
    #1;
    n_vec++; if (core_rvalid !== 4'b0001) begin n_err++; $display("FAIL full_pop: got %b expected 0001", core_rvalid); end
    n_vec++; if (apu_req !== 1'b0) begin n_err++; $display("FAIL full_req_pop: got %b expected 0", apu_req); end
    cyc();
    apu_rvalid = 1'b0;
    #1;
    n_vec++; if (apu_req !== 1'b1) begin n_err++; $display("FAIL full_rearm: got %b expected 1", apu_req); end
    n_vec++; if (core_gnt !== 4'b0001) begin n_err++; $display("FAIL full_rearm_gnt: got %b expected 0001", core_gnt); end
    n_vec++; if (outstanding !== 3'd3) begin n_err++; $display("FAIL full_count3: got %0d expected 3", outstanding); end
    cyc();
    core_req = '0; apu_rvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e = 4'b0001 << ((k + 1) % 4);
      #1;
      n_vec++; if (core_rvalid !== e) begin n_err++; $display("FAIL full_drain[%0d]: got %b expected %b", k, core_rvalid, e); end
      cyc();
    end
    apu_rvalid = 1'b0;
    #1;
    n_vec++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL full_empty: got %0d expected 0", outstanding); end
  endtask

  task automatic test_simul;
    apply_reset();
    core_req = 4'hF; apu_gnt = 1'b1;
    cyc(); cyc();
    apu_rvalid = 1'b1;
    #1;
    n_vec++; if (outstanding !== 3'd2) begin n_err++; $display("FAIL simul_pre: got %0d expected 2", outstanding); end
    n_vec++; if (core_gnt !== 4'b0100) begin n_err++; $display("FAIL simul_gnt: got %b expected 0100", core_gnt); end
    n_vec++; if (core_rvalid !== 4'b0001) begin n_err++; $display("FAIL simul_rvalid: got %b expected 0001", core_rvalid); end
    cyc();
    core_req = '0;
    #1;
    n_vec++; if (outstanding !== 3'd2) begin n_err++; $display("FAIL simul_post: got %0d expected 2", outstanding); end
    n_vec++; if (core_rvalid !== 4'b0010) begin n_err++; $display("FAIL simul_resp1: got %b expected 0010", core_rvalid); end
    cyc();
    #1;
    n_vec++; if (core_rvalid !== 4'b0100) begin n_err++; $display("FAIL simul_resp2: got %b expected 0100", core_rvalid); end
    cyc();
    apu_rvalid = 1'b0;
  endtask

  task automatic test_spurious;
    apply_reset();
    apu_rvalid = 1'b1;
    #1;
    n_vec++; if (core_rvalid !== 4'b0000) begin n_err++; $display("FAIL spur_rvalid: got %b expected 0000", core_rvalid); end
    cyc();
    apu_rvalid = 1'b0;
    #1;
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL spur_err: got %b expected 1", err); end
    cyc();
    #1;
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL spur_sticky: got %b expected 1", err); end
    rst_ni = 1'b0;
    cyc();
    rst_ni = 1'b1;
    #1;
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL spur_clear: got %b expected 0", err); end
  endtask

  task automatic test_random;
    apply_reset();
    model_reset();
    for (int t = 0; t < 3000; t++) begin
      randomize_payload();
      core_req   = N'($urandom);
      apu_gnt    = 1'($urandom_range(0, 1));
      apu_rvalid = (m_q.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 199) == 0);
      rst_ni     = ($urandom_range(0, 299) != 0);
      #1;
      model_predict();
      n_vec++; if (apu_req !== exp_req) begin n_err++; $display("FAIL rnd_req @%0d: got %b expected %b", t, apu_req, exp_req); end
      n_vec++; if (core_gnt !== exp_gnt) begin n_err++; $display("FAIL rnd_gnt @%0d: got %b expected %b", t, core_gnt, exp_gnt); end
      n_vec++; if (core_rvalid !== exp_rvalid) begin n_err++; $display("FAIL rnd_rvalid @%0d: got %b expected %b", t, core_rvalid, exp_rvalid); end
      n_vec++; if (outstanding !== m_q.size()) begin n_err++; $display("FAIL rnd_outstanding @%0d: got %0d expected %0d", t, outstanding, m_q.size()); end
      n_vec++; if (err !== m_err) begin n_err++; $display("FAIL rnd_err @%0d: got %b expected %b", t, err, m_err); end
      n_vec++; if (core_result !== apu_result) begin n_err++; $display("FAIL rnd_result @%0d: got %h expected %h", t, core_result, apu_result); end
      if (exp_req) begin
        n_vec++;
        if (apu_op !== core_op[exp_sel] || apu_operands !== core_operands[exp_sel] || apu_flags !== core_flags[exp_sel]) begin
          n_err++;
          $display("FAIL rnd_payload @%0d: got op %h expected op %h (core %0d)", t, apu_op, core_op[exp_sel], exp_sel);
        end
      end
      @(posedge clk);
      model_commit();
      @(negedge clk);
    end
    rst_ni = 1'b1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_ni = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_wait_gnt();
    test_full();
    test_simul();
    test_spurious();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cv32e40p_apu_arbiter.md
Name: cv32e40p_apu_arbiter

Overview:
- Shares one APU/FPU instance among NUM_CORES cv32e40p cores in a PULP cluster.
- Each core's apu_req/gnt/operands/op/flags port connects to a core side here. One downstream port drives the shared APU.
- Round-robin arbitration with a locked grant while waiting.
- The APU returns results in order. The block tracks outstanding requests in a requester-ID FIFO so each result is routed back to the core that issued it.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..16).
- APU_NARGS, 3, operands per request, each 32 bits.
- APU_WOP, 6, op code width.
- APU_NDSFLAGS, 15, downstream flag width (request side).
- APU_NUSFLAGS, 5, upstream flag width (response side).
- MAX_OUTST, 4, depth of the ID FIFO; power of 2, at least 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- core_req_i  in  NUM_CORES  per-core request
- core_gnt_o  out  NUM_CORES  per-core grant
- core_operands_i  in  NUM_CORES x APU_NARGS x 32  per-core operands
- core_op_i  in  NUM_CORES x APU_WOP  per-core op
- core_flags_i  in  NUM_CORES x APU_NDSFLAGS  per-core request flags
- core_rvalid_o  out  NUM_CORES  per-core result valid
- core_result_o  out  32  result, broadcast to all cores
- core_flags_o  out  APU_NUSFLAGS  response flags, broadcast to all cores
- apu_req_o  out  1  request to shared APU
- apu_gnt_i  in  1  grant from APU
- apu_operands_o  out  APU_NARGS x 32  operands to APU
- apu_op_o  out  APU_WOP  op to APU
- apu_flags_o  out  APU_NDSFLAGS  flags to APU
- apu_rvalid_i  in  1  APU result valid
- apu_result_i  in  32  APU result
- apu_flags_i  in  APU_NUSFLAGS  APU response flags
- outstanding_o  out  $clog2(MAX_OUTST)+1  number of granted, unanswered requests
- err_o  out  1  sticky: apu_rvalid_i received with no request outstanding

Behaviour:
- Reset: on a rising clk_i edge with rst_ni=0, all of the following are cleared:
  - FSM goes to IDLE.
  - RR pointer = 0, locked index = 0.
  - FIFO empty, outstanding_o = 0, err_o = 0.
  - Consequently apu_req_o = 0, core_gnt_o = 0, core_rvalid_o = 0.
- Reset mid-operation: in-flight requests are dropped. APU responses arriving after reset count as spurious; the integrator resets the APU together with this block.
- full = (outstanding_o == MAX_OUTST).
- FSM state IDLE:
  - winner = first i with core_req_i[i]=1, searching from RR pointer upward with wrap at NUM_CORES.
  - apu_req_o = any(core_req_i) & ~full. Payload is muxed combinationally from the winner.
  - If apu_gnt_i=1 and apu_req_o=1: handshake happens, state stays IDLE.
  - If apu_req_o=1 and apu_gnt_i=0: latch winner into the locked index and go to WAIT_GNT.
- FSM state WAIT_GNT:
  - apu_req_o = 1 and payload is taken from the locked index, regardless of other requests and regardless of full.
  - On apu_gnt_i=1: handshake happens, go to IDLE.
  - Cores keep req and payload stable until granted. Dropping req here is a protocol violation and the arbiter still holds apu_req_o.
- Handshake (apu_req_o & apu_gnt_i), in the same cycle:
  - core_gnt_o[sel]=1, combinational, only for the selected core; all other grants are 0.
  - Push sel into the FIFO.
  - RR pointer <= (sel+1) mod NUM_CORES.
- Latency: a request to an idle, granting APU is granted combinationally in the same cycle; there are no added arbitration cycles.
- Response path:
  - apu_rvalid_i=1 with FIFO non-empty: core_rvalid_o[head]=1 combinationally, then pop.
  - core_result_o = apu_result_i and core_flags_o = apu_flags_i at all times.
- Simultaneous push and pop: both take effect and outstanding_o is unchanged. This is allowed even when full, because the pop frees the slot. full is evaluated from the registered count, so apu_req_o stays 0 in IDLE that cycle.
- Spurious response: apu_rvalid_i=1 with FIFO empty (outstanding_o=0, no pop) → no core_rvalid_o is raised and err_o is set to 1, staying set until reset.
- FIFO pointers wrap modulo MAX_OUTST; the count saturates by construction.
- NUM_CORES not a power of 2: RR wrap is explicit modulo NUM_CORES; indices NUM_CORES and above are never selected.

Test Plan:
- Single core 1 requests while apu_gnt_i is tied to 1:
  - core_gnt_o=4'b0010 in the same cycle.
  - apu_rvalid_i two cycles later gives core_rvalid_o=4'b0010.
  - core_result_o equals apu_result_i.
- All 4 cores hold req continuously with apu_gnt_i=1 and rvalid in the following cycle:
  - Grants rotate 0,1,2,3,0.
  - Responses return to 0,1,2,3,0 in order.
  - outstanding_o never exceeds 1.
- Cores 2 and 3 request while apu_gnt_i=0 for 3 cycles:
  - FSM enters WAIT_GNT locked on core 2, and apu_op_o equals core 2's op for all 3 cycles.
  - On the grant, core_gnt_o=4'b0100. Core 3 is granted next.
- apu_gnt_i=1 with no rvalid until 4 handshakes have completed:
  - outstanding_o=4 and apu_req_o=0.
  - One apu_rvalid_i pops the FIFO and routes the first requester's ID.
  - apu_req_o reasserts the following cycle.
- Same-cycle handshake and response with outstanding_o=2: outstanding_o stays at 2 and the correct core receives rvalid.
- apu_rvalid_i pulsed after reset with no request: err_o=1, core_rvalid_o=0; driving rst_ni=0 for one edge clears err_o.
